// File: rtl/acc_dump_ctrl_pkg.sv
// Shared types and defaults for the integrate-and-dump controller.
//   state_t      : controller FSM states (ACCUM collects samples, DUMP holds a sum)
//   *_DEF        : default widths used by the top and its interface
package acc_dump_ctrl_pkg;

  localparam int unsigned IWIDTH_DEF = 16;
  localparam int unsigned OWIDTH_DEF = 30;
  localparam int unsigned CWIDTH_DEF = 8;

  typedef enum logic {
    ACCUM = 1'b0,
    DUMP  = 1'b1
  } state_t;

endpackage

// File: rtl/acc_dump_ctrl_if.sv
// Sample-in / sum-out stream pair of the integrate-and-dump controller.
//   in_tdata/in_tvalid/in_tready    : signed sample stream into the block
//   out_tdata/out_tvalid/out_tready : signed block-sum stream out of the block
//   slave  : controller view (consumes samples, produces sums)
//   master : environment view (produces samples, consumes sums)
interface acc_dump_ctrl_if #(
  parameter int unsigned IWIDTH = 16,
  parameter int unsigned OWIDTH = 30
);

  logic [IWIDTH-1:0] in_tdata;
  logic              in_tvalid;
  logic              in_tready;
  logic [OWIDTH-1:0] out_tdata;
  logic              out_tvalid;
  logic              out_tready;

  modport slave (
    input  in_tdata, in_tvalid, out_tready,
    output in_tready, out_tdata, out_tvalid
  );

  modport master (
    output in_tdata, in_tvalid, out_tready,
    input  in_tready, out_tdata, out_tvalid
  );

endinterface

// File: rtl/acc_dump_ctrl_acc.sv
// Sign-extending accumulator with a registered output.
//   clk   : rising-edge clock
//   clear : with acc, load the sample instead of adding to the running sum
//   acc   : update enable; the register holds when low
//   din   : signed sample, IWIDTH bits
//   dout  : running sum, OWIDTH bits, wraps modulo 2^OWIDTH
// The register has no reset: its content is only meaningful after a load.
module acc_dump_ctrl_acc #(
  parameter int unsigned IWIDTH = 16,
  parameter int unsigned OWIDTH = 30
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              acc,
  input  logic [IWIDTH-1:0] din,
  output logic [OWIDTH-1:0] dout
);

  logic [OWIDTH-1:0] din_ext;

  // Sized cast of a signed operand sign-extends.
  assign din_ext = OWIDTH'($signed(din));

  always_ff @(posedge clk) begin
    if (acc) begin
      dout <= (clear ? '0 : dout) + din_ext;
    end
  end

endmodule

// File: rtl/acc_dump_ctrl.sv
// Integrate-and-dump controller: sums blocks of `rate` accepted samples and
// presents one sum per block on the output stream.
//   clk      : rising-edge clock
//   reset    : asynchronous, active-high
//   rate     : samples per block (0 behaves as 1), loaded on rate_stb
//   rate_stb : one-cycle strobe, loads rate and abandons any partial block
//   bus      : sample-in / sum-out streams (slave view)
module acc_dump_ctrl
  import acc_dump_ctrl_pkg::*;
#(
  parameter int unsigned IWIDTH = IWIDTH_DEF,
  parameter int unsigned OWIDTH = OWIDTH_DEF,
  parameter int unsigned CWIDTH = CWIDTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CWIDTH-1:0] rate,
  input  logic              rate_stb,
  acc_dump_ctrl_if.slave    bus
);

  localparam logic [CWIDTH-1:0] RATE_RST = CWIDTH'(1);

  state_t            state;
  logic [CWIDTH-1:0] cnt;
  logic [CWIDTH-1:0] rate_r;
  logic [CWIDTH-1:0] eff_rate;
  logic              out_valid;
  logic              in_ready;
  logic              in_beat;
  logic              out_beat;
  logic              last_beat;
  logic              acc_clear;
  logic              acc_en;

  // Block length; a zero rate degenerates to one-sample blocks.
  assign eff_rate  = (rate_r == '0) ? CWIDTH'(1) : rate_r;

  // Input stalls only behind an unconsumed sum, so a sum can be taken and
  // the next block started in the same cycle.
  assign out_valid = (state == DUMP);
  assign in_ready  = ~reset & ~rate_stb & ~(out_valid & ~bus.out_tready);
  assign in_beat   = bus.in_tvalid & in_ready;
  assign out_beat  = out_valid & bus.out_tready;
  assign last_beat = in_beat & (cnt == (eff_rate - CWIDTH'(1)));

  // First sample of a block loads, later ones add, otherwise hold.
  assign acc_en    = in_beat;
  assign acc_clear = in_beat & (cnt == '0);

  assign bus.in_tready  = in_ready;
  assign bus.out_tvalid = out_valid;

  // Rate register, per-block sample counter and ACCUM/DUMP sequencing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ACCUM;
      cnt    <= '0;
      rate_r <= RATE_RST;
    end else begin
      if (rate_stb) begin
        rate_r <= rate;
        cnt    <= '0;
      end else if (in_beat) begin
        cnt <= last_beat ? '0 : cnt + CWIDTH'(1);
      end

      case (state)
        ACCUM: begin
          if (last_beat) begin
            state <= DUMP;
          end
        end
        DUMP: begin
          // A sample taken alongside the dump only closes a block when blocks
          // are one sample long.
          if (out_beat) begin
            state <= last_beat ? DUMP : ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

  acc_dump_ctrl_acc #(
    .IWIDTH (IWIDTH),
    .OWIDTH (OWIDTH)
  ) u_acc (
    .clk   (clk),
    .clear (acc_clear),
    .acc   (acc_en),
    .din   (bus.in_tdata),
    .dout  (bus.out_tdata)
  );

endmodule
